// File: rtl/change_dispenser.sv
// Coin payout sequencer: pays a change amount largest-coin-first through a
// req/ack hopper handshake, skipping empty tubes, with a hopper ack timeout.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start; residue/coins_out from last payout held
//   S_PICK  | choose largest available coin that fits the remaining amount
//   S_REQ   | coin_req high, waiting for coin_ack (timer running)
//   S_REL   | coin paid, waiting for hopper to release coin_ack
//   S_DONE  | one-cycle done pulse
//   S_FAULT | hopper timed out; hold until clr_fault
module change_dispenser #(
  parameter int N           = 10,
  parameter int V0          = 10,
  parameter int V1          = 20,
  parameter int V2          = 50,
  parameter int V3          = 100,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] balance,
  input  logic [3:0]   tube_empty,
  input  logic         coin_ack,
  input  logic         clr_fault,
  output logic         coin_req,
  output logic [1:0]   coin_sel,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] residue,
  output logic [7:0]   coins_out,
  output logic         fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_REQ, S_REL, S_DONE, S_FAULT
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [N-1:0] amt_q, amt_d;
  logic [1:0]   sel_q, sel_d;
  logic [7:0]   timer_q, timer_d;
  logic [7:0]   coins_q, coins_d;
  logic [N-1:0] residue_q, residue_d;

  logic         pick_found;
  logic [1:0]   pick_sel;

  function automatic logic [N-1:0] coin_val(input logic [1:0] s);
    case (s)
      2'd0:    coin_val = N'(V0);
      2'd1:    coin_val = N'(V1);
      2'd2:    coin_val = N'(V2);
      default: coin_val = N'(V3);
    endcase
  endfunction

  // Ascending scan: the last match wins, giving the largest usable coin.
  always_comb begin
    pick_found = 1'b0;
    pick_sel   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!tube_empty[i] && (amt_q >= coin_val(2'(i)))) begin
        pick_found = 1'b1;
        pick_sel   = 2'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    amt_d     = amt_q;
    sel_d     = sel_q;
    timer_d   = timer_q;
    coins_d   = coins_q;
    residue_d = residue_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          amt_d     = balance;
          coins_d   = 8'd0;
          residue_d = '0;
          state_d   = S_PICK;
        end
      end
      S_PICK: begin
        if (pick_found) begin
          sel_d   = pick_sel;
          timer_d = 8'd0;
          state_d = S_REQ;
        end else begin
          residue_d = amt_q;
          state_d   = S_DONE;
        end
      end
      S_REQ: begin
        if (coin_ack) begin
          amt_d = amt_q - coin_val(sel_q);
          if (coins_q != 8'hFF) coins_d = coins_q + 8'd1;
          state_d = S_REL;
        end else if (timer_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_REL: begin
        if (!coin_ack) state_d = S_PICK;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (clr_fault) begin
          residue_d = amt_q;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      amt_q     <= '0;
      sel_q     <= 2'd0;
      timer_q   <= 8'd0;
      coins_q   <= 8'd0;
      residue_q <= '0;
    end else begin
      state_q   <= state_d;
      amt_q     <= amt_d;
      sel_q     <= sel_d;
      timer_q   <= timer_d;
      coins_q   <= coins_d;
      residue_q <= residue_d;
    end
  end

  assign coin_req  = (state_q == S_REQ);
  assign coin_sel  = sel_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign fault     = (state_q == S_FAULT);
  assign residue   = residue_q;
  assign coins_out = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: acking hopper model driven from a task,
// expected coin sequences, residues and latencies computed by hand.
module tb_change_dispenser;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] balance;
  logic [3:0] tube_empty;
  logic       coin_ack;
  logic       clr_fault;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       busy;
  logic       done;
  logic [9:0] residue;
  logic [7:0] coins_out;
  logic       fault;

  int n_vec;
  int n_err;

  change_dispenser dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .balance    (balance),
    .tube_empty (tube_empty),
    .coin_ack   (coin_ack),
    .clr_fault  (clr_fault),
    .coin_req   (coin_req),
    .coin_sel   (coin_sel),
    .busy       (busy),
    .done       (done),
    .residue    (residue),
    .coins_out  (coins_out),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a payout and plays the hopper (ack on the 2nd cycle of each request)
  // until done or fault is seen. Returns with the DUT outputs of that cycle visible.
  task automatic run_payout(input logic [9:0] bal, input logic [3:0] tubes, input bit ack_en,
                            input int restart_cyc, input logic [9:0] restart_bal,
                            output int n_coins, output logic [15:0] sel_seq,
                            output int first_req, output int end_cyc);
    int  req_wait;
    bit  finished;
    n_coins   = 0;
    sel_seq   = 16'h0;
    first_req = -1;
    end_cyc   = -1;
    req_wait  = 0;
    finished  = 1'b0;
    @(negedge clk);
    tube_empty = tubes;
    balance    = bal;
    start      = 1'b1;
    for (int cyc = 1; cyc <= 600 && !finished; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_cyc);
      if (cyc == restart_cyc) balance = restart_bal;
      if (coin_req) begin
        if (first_req < 0) first_req = cyc;
        if (ack_en && !coin_ack) begin
          req_wait++;
          if (req_wait == 2) begin
            coin_ack = 1'b1;
            sel_seq  = {sel_seq[13:0], coin_sel};
            n_coins++;
          end
        end
      end else begin
        req_wait = 0;
        coin_ack = 1'b0;
      end
      if (done || fault) begin
        finished = 1'b1;
        end_cyc  = cyc;
      end
    end
    start = 1'b0;
    chk("payout_in_budget", 32'(finished), 32'd1);
  endtask

  int          nc, fr, ec;
  logic [15:0] seq;

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b0;
    start      = 1'b0;
    balance    = '0;
    tube_empty = 4'b0000;
    coin_ack   = 1'b0;
    clr_fault  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_coin_req", 32'(coin_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_residue", 32'(residue), 0);
    chk("rst_coins_out", 32'(coins_out), 0);
    rst = 1'b1;

    // 180 with all tubes: 100, 50, 20, 10
    run_payout(10'd180, 4'b0000, 1'b1, -1, '0, nc, seq, fr, ec);
    chk("t1_sel_seq", 32'(seq[7:0]), 32'hE4);
    chk("t1_ncoins", nc, 4);
    chk("t1_first_req_cyc", fr, 2);
    chk("t1_done_cyc", ec, 18);
    chk("t1_done", 32'(done), 1);
    chk("t1_residue", 32'(residue), 0);
    chk("t1_coins_out", 32'(coins_out), 4);
    @(negedge clk);
    chk("t1_done_once", 32'(done), 0);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_coins_hold", 32'(coins_out), 4);

    // 70 with the 50 tube empty: 20, 20, 20, 10
    run_payout(10'd70, 4'b0100, 1'b1, -1, '0, nc, seq, fr, ec);
    chk("t2_sel_seq", 32'(seq[7:0]), 32'h54);
    chk("t2_ncoins", nc, 4);
    chk("t2_residue", 32'(residue), 0);
    chk("t2_coins_out", 32'(coins_out), 4);

    run_payout(10'd15, 4'b0000, 1'b1, -1, '0, nc, seq, fr, ec);
    chk("t3a_ncoins", nc, 1);
    chk("t3a_sel", 32'(seq[1:0]), 0);
    chk("t3a_residue", 32'(residue), 5);
    chk("t3a_coins_out", 32'(coins_out), 1);

    run_payout(10'd0, 4'b0000, 1'b1, -1, '0, nc, seq, fr, ec);
    chk("t3b_first_req", fr, -1);
    chk("t3b_done_cyc", ec, 2);
    chk("t3b_residue", 32'(residue), 0);
    chk("t3b_coins_out", 32'(coins_out), 0);

    // Silent hopper: REQ entered at cycle 2, 255 cycles later FAULT
    run_payout(10'd50, 4'b0000, 1'b0, -1, '0, nc, seq, fr, ec);
    chk("t4_fault_cyc", ec, 257);
    chk("t4_fault", 32'(fault), 1);
    chk("t4_coin_req", 32'(coin_req), 0);
    chk("t4_busy", 32'(busy), 1);
    repeat (3) @(negedge clk);
    chk("t4_fault_held", 32'(fault), 1);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    chk("t4_done", 32'(done), 1);
    chk("t4_residue", 32'(residue), 50);
    chk("t4_coins_out", 32'(coins_out), 0);
    @(negedge clk);
    chk("t4_fault_clear", 32'(fault), 0);
    chk("t4_idle", 32'(busy), 0);

    // Asynchronous reset in the middle of a request
    balance = 10'd100;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("t5_req_before_rst", 32'(coin_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_coin_req", 32'(coin_req), 0);
    chk("t5_async_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    run_payout(10'd20, 4'b0000, 1'b1, -1, '0, nc, seq, fr, ec);
    chk("t5_after_ncoins", nc, 1);
    chk("t5_after_sel", 32'(seq[1:0]), 1);
    chk("t5_after_residue", 32'(residue), 0);

    // A second start while busy must be ignored
    run_payout(10'd180, 4'b0000, 1'b1, 4, 10'd50, nc, seq, fr, ec);
    chk("t6_sel_seq", 32'(seq[7:0]), 32'hE4);
    chk("t6_ncoins", nc, 4);
    chk("t6_done_cyc", ec, 18);
    chk("t6_residue", 32'(residue), 0);
    @(negedge clk);
    chk("t6_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
